// File: rtl/forwarding_network.sv
// Operand-forwarding network for the execution stage. Each source operand is
// resolved from the youngest matching producer, then a stall hold register, then the register file.
module forwarding_network #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADD_WIDTH = 5,
  parameter int NUM_SRC       = 2,
  parameter int NUM_STAGES    = 4,
  parameter int ZERO_REG_HARD = 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             STALL_EXECUTION_STAGE,
  input  logic [NUM_SRC*REG_ADD_WIDTH-1:0]    RS_ADDRESS_EXECUTION,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]       RS_DATA_EXECUTION,
  input  logic [NUM_STAGES*REG_ADD_WIDTH-1:0] RD_ADDRESS,
  input  logic [NUM_STAGES-1:0]               RD_WRITE_ENABLE,
  input  logic [NUM_STAGES-1:0]               RD_DATA_VALID,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0]    RD_DATA,
  output logic [NUM_SRC*DATA_WIDTH-1:0]       RS_DATA,
  output logic [NUM_SRC-1:0]                  FORWARD_HIT,
  output logic                                DATA_HAZARD
);

  localparam int WB_STAGE = NUM_STAGES - 1;

  logic [NUM_SRC-1:0] hazard_vec;

  genvar gi;
  genvar gk;

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ADD_WIDTH-1:0] rs_addr;
      logic [DATA_WIDTH-1:0]    rs_file_data;
      logic                     addr_is_zero;
      logic [NUM_STAGES-1:0]    match_vec;

      // Selection chain: entry k holds the youngest match among stages k..WB.
      logic [NUM_STAGES:0]      found_chain;
      logic [NUM_STAGES:0]      valid_chain;
      logic [DATA_WIDTH-1:0]    data_chain [NUM_STAGES+1];

      logic                     hold_valid_reg;
      logic                     hold_valid_next;
      logic [DATA_WIDTH-1:0]    hold_data_reg;
      logic [DATA_WIDTH-1:0]    hold_data_next;

      logic [DATA_WIDTH-1:0]    operand_data;
      logic                     operand_hit;
      logic                     operand_hazard;

      assign rs_addr      = RS_ADDRESS_EXECUTION[gi*REG_ADD_WIDTH +: REG_ADD_WIDTH];
      assign rs_file_data = RS_DATA_EXECUTION[gi*DATA_WIDTH +: DATA_WIDTH];
      assign addr_is_zero = (ZERO_REG_HARD != 0) && (rs_addr == '0);

      assign found_chain[NUM_STAGES] = 1'b0;
      assign valid_chain[NUM_STAGES] = 1'b0;
      assign data_chain[NUM_STAGES]  = '0;

      for (gk = 0; gk < NUM_STAGES; gk++) begin : g_stage
        assign match_vec[gk] = RD_WRITE_ENABLE[gk]
                            && (RD_ADDRESS[gk*REG_ADD_WIDTH +: REG_ADD_WIDTH] == rs_addr)
                            && !addr_is_zero;
        assign found_chain[gk] = match_vec[gk] || found_chain[gk+1];
        assign valid_chain[gk] = match_vec[gk] ? RD_DATA_VALID[gk] : valid_chain[gk+1];
        assign data_chain[gk]  = match_vec[gk] ? RD_DATA[gk*DATA_WIDTH +: DATA_WIDTH]
                                               : data_chain[gk+1];
      end

      // A matching producer without data still owns the operand: no fall-through to older stages.
      always_comb begin
        operand_data   = rs_file_data;
        operand_hit    = 1'b0;
        operand_hazard = 1'b0;
        if (found_chain[0]) begin
          operand_hit = 1'b1;
          if (valid_chain[0]) begin
            operand_data = data_chain[0];
          end else begin
            operand_hazard = 1'b1;
          end
        end else if (hold_valid_reg) begin
          operand_hit  = 1'b1;
          operand_data = hold_data_reg;
        end
      end

      always_comb begin
        hold_valid_next = hold_valid_reg;
        hold_data_next  = hold_data_reg;
        if (!STALL_EXECUTION_STAGE) begin
          hold_valid_next = 1'b0;
          hold_data_next  = '0;
        end else if (match_vec[WB_STAGE] && RD_DATA_VALID[WB_STAGE]) begin
          hold_valid_next = 1'b1;
          hold_data_next  = RD_DATA[WB_STAGE*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          hold_valid_reg <= 1'b0;
          hold_data_reg  <= '0;
        end else begin
          hold_valid_reg <= hold_valid_next;
          hold_data_reg  <= hold_data_next;
        end
      end

      assign RS_DATA[gi*DATA_WIDTH +: DATA_WIDTH] = operand_data;
      assign FORWARD_HIT[gi]                      = operand_hit;
      assign hazard_vec[gi]                       = operand_hazard;
    end
  endgenerate

  assign DATA_HAZARD = |hazard_vec;

endmodule

// File: tb/tb_forwarding_network.sv
// Scoreboarded bench for forwarding_network (3 operands, 6 stages): directed
// corner cases followed by randomized traffic against a behavioural model.
module tb_forwarding_network;

  localparam int DW     = 32;
  localparam int A      = 5;
  localparam int NS     = 3;
  localparam int NK     = 6;
  localparam int WB     = NK - 1;
  localparam int N_RAND = 10000;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              STALL_EXECUTION_STAGE = 1'b0;
  logic [NS*A-1:0]   RS_ADDRESS_EXECUTION = '0;
  logic [NS*DW-1:0]  RS_DATA_EXECUTION = '0;
  logic [NK*A-1:0]   RD_ADDRESS = '0;
  logic [NK-1:0]     RD_WRITE_ENABLE = '0;
  logic [NK-1:0]     RD_DATA_VALID = '0;
  logic [NK*DW-1:0]  RD_DATA = '0;
  logic [NS*DW-1:0]  RS_DATA;
  logic [NS-1:0]     FORWARD_HIT;
  logic              DATA_HAZARD;

  forwarding_network #(
    .DATA_WIDTH(DW), .REG_ADD_WIDTH(A), .NUM_SRC(NS), .NUM_STAGES(NK), .ZERO_REG_HARD(1)
  ) dut (
    .CLK(CLK), .RST(RST), .STALL_EXECUTION_STAGE(STALL_EXECUTION_STAGE),
    .RS_ADDRESS_EXECUTION(RS_ADDRESS_EXECUTION), .RS_DATA_EXECUTION(RS_DATA_EXECUTION),
    .RD_ADDRESS(RD_ADDRESS), .RD_WRITE_ENABLE(RD_WRITE_ENABLE), .RD_DATA_VALID(RD_DATA_VALID),
    .RD_DATA(RD_DATA), .RS_DATA(RS_DATA), .FORWARD_HIT(FORWARD_HIT), .DATA_HAZARD(DATA_HAZARD)
  );

  always #5 CLK = ~CLK;

  // Stimulus staged for the next cycle
  logic           nx_rst, nx_stall;
  logic [A-1:0]   nx_rs_a [NS];
  logic [DW-1:0]  nx_rs_d [NS];
  logic           nx_we   [NK];
  logic           nx_val  [NK];
  logic [A-1:0]   nx_rd_a [NK];
  logic [DW-1:0]  nx_rd_d [NK];

  // Reference model: value retired by WB during the current stall, per operand
  logic           m_hold_v [NS];
  logic [DW-1:0]  m_hold_d [NS];

  typedef struct {
    int              id;
    string           tag;
    logic [NS*DW-1:0] data;
    logic [NS-1:0]   hit;
    logic            haz;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared = 0;
  int   n_mismatch = 0;
  int   txn_id     = 0;

  task automatic clear_next();
    nx_rst   = 1'b0;
    nx_stall = 1'b0;
    for (int i = 0; i < NS; i++) begin
      nx_rs_a[i] = '0;
      nx_rs_d[i] = $urandom();
    end
    for (int k = 0; k < NK; k++) begin
      nx_we[k]   = 1'b0;
      nx_val[k]  = 1'b1;
      nx_rd_a[k] = '0;
      nx_rd_d[k] = $urandom();
    end
  endtask

  function automatic logic writes_reg(int k, logic [A-1:0] r);
    return nx_we[k] && (nx_rd_a[k] == r) && (r != '0);
  endfunction

  task automatic step(input string tag);
    exp_t e;
    int   src_k;
    @(posedge CLK);
    #1;
    RST = nx_rst;
    STALL_EXECUTION_STAGE = nx_stall;
    for (int i = 0; i < NS; i++) begin
      RS_ADDRESS_EXECUTION[i*A +: A] = nx_rs_a[i];
      RS_DATA_EXECUTION[i*DW +: DW]  = nx_rs_d[i];
    end
    for (int k = 0; k < NK; k++) begin
      RD_WRITE_ENABLE[k]      = nx_we[k];
      RD_DATA_VALID[k]        = nx_val[k];
      RD_ADDRESS[k*A +: A]    = nx_rd_a[k];
      RD_DATA[k*DW +: DW]     = nx_rd_d[k];
    end

    e.id  = txn_id;
    e.tag = tag;
    e.haz = 1'b0;
    e.hit = '0;
    e.data = '0;
    txn_id++;
    for (int i = 0; i < NS; i++) begin
      src_k = -1;
      for (int k = 0; k < NK; k++)
        if (src_k < 0 && writes_reg(k, nx_rs_a[i])) src_k = k;
      e.data[i*DW +: DW] = nx_rs_d[i];
      if (src_k >= 0) begin
        e.hit[i] = 1'b1;
        if (nx_val[src_k]) e.data[i*DW +: DW] = nx_rd_d[src_k];
        else               e.haz = 1'b1;
      end else if (m_hold_v[i]) begin
        e.hit[i] = 1'b1;
        e.data[i*DW +: DW] = m_hold_d[i];
      end
    end
    sb_q.push_back(e);

    for (int i = 0; i < NS; i++) begin
      if (nx_rst || !nx_stall) begin
        m_hold_v[i] = 1'b0;
        m_hold_d[i] = '0;
      end else if (writes_reg(WB, nx_rs_a[i]) && nx_val[WB]) begin
        m_hold_v[i] = 1'b1;
        m_hold_d[i] = nx_rd_d[WB];
      end
    end
  endtask

  // Monitor: outputs are combinational, so one transaction is compared per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_compared += 3;
        if (RS_DATA !== e.data) begin
          n_mismatch++;
          $display("FAIL %s #%0d rs_data got %h want %h", e.tag, e.id, RS_DATA, e.data);
        end
        if (FORWARD_HIT !== e.hit) begin
          n_mismatch++;
          $display("FAIL %s #%0d forward_hit got %b want %b", e.tag, e.id, FORWARD_HIT, e.hit);
        end
        if (DATA_HAZARD !== e.haz) begin
          n_mismatch++;
          $display("FAIL %s #%0d data_hazard got %b want %b", e.tag, e.id, DATA_HAZARD, e.haz);
        end
        $display("txn %0d %s rs_data=%h hit=%b haz=%b", e.id, e.tag, RS_DATA, FORWARD_HIT, DATA_HAZARD);
      end
    end
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      m_hold_v[i] = 1'b0;
      m_hold_d[i] = '0;
    end

    clear_next(); nx_rst = 1'b1; step("reset");
    clear_next(); nx_rst = 1'b1; nx_stall = 1'b1; step("reset");

    clear_next();
    nx_rs_a[0] = 5'd5;
    nx_we[0] = 1'b1; nx_rd_a[0] = 5'd5; nx_rd_d[0] = 32'hAAAA;
    nx_we[2] = 1'b1; nx_rd_a[2] = 5'd5; nx_rd_d[2] = 32'hCCCC;
    step("priority");

    clear_next();
    nx_rs_a[1] = 5'd0;
    nx_we[1] = 1'b1; nx_rd_a[1] = 5'd0; nx_rd_d[1] = 32'h1234;
    step("x0");

    clear_next();
    nx_rs_a[0] = 5'd7;
    nx_we[0] = 1'b1; nx_rd_a[0] = 5'd7; nx_val[0] = 1'b0;
    nx_we[3] = 1'b1; nx_rd_a[3] = 5'd7; nx_rd_d[3] = 32'h55;
    step("load_use");

    clear_next(); nx_stall = 1'b1; nx_rs_a[0] = 5'd9;
    nx_we[WB] = 1'b1; nx_rd_a[WB] = 5'd9; nx_rd_d[WB] = 32'hDEAD;
    step("stall_c1");
    clear_next(); nx_stall = 1'b1; nx_rs_a[0] = 5'd9;
    nx_we[WB] = 1'b1; nx_rd_a[WB] = 5'd9; nx_rd_d[WB] = 32'hBEEF;
    step("stall_c2");
    clear_next(); nx_stall = 1'b1; nx_rs_a[0] = 5'd9; step("stall_c3");
    clear_next(); nx_rs_a[0] = 5'd9; step("unstall");
    clear_next(); nx_rs_a[0] = 5'd9; step("after");

    clear_next(); nx_stall = 1'b1; nx_rs_a[0] = 5'd9; nx_rs_a[2] = 5'd9;
    nx_we[WB] = 1'b1; nx_rd_a[WB] = 5'd9; nx_rd_d[WB] = 32'h77;
    step("rst_cap");
    clear_next(); nx_stall = 1'b1; nx_rst = 1'b1; nx_rs_a[0] = 5'd9; nx_rs_a[2] = 5'd9;
    step("rst_mid");
    clear_next(); nx_stall = 1'b1; nx_rs_a[0] = 5'd9; nx_rs_a[2] = 5'd9;
    step("rst_after");

    for (int n = 0; n < N_RAND; n++) begin
      clear_next();
      nx_rst   = ($urandom_range(0, 49) == 0);
      nx_stall = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NS; i++) nx_rs_a[i] = A'($urandom_range(0, 7));
      for (int k = 0; k < NK; k++) begin
        nx_we[k]   = ($urandom_range(0, 2) == 0);
        nx_val[k]  = ($urandom_range(0, 3) != 0);
        nx_rd_a[k] = A'($urandom_range(0, 7));
      end
      step("random");
    end

    for (int w = 0; w < 4 && sb_q.size() != 0; w++) @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      n_compared++;
      n_mismatch++;
      $display("FAIL drain pending got %0d want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
